// File: rtl/dmem_pkg.sv
// Shared types and constants for the line-granular data memory controller.
package dmem_pkg;
    localparam int LINE_BYTES      = 32;
    localparam int OFFSET_W        = 5;
    localparam int ADDR_W          = 32;
    localparam int DEFAULT_LINE_W  = 256;
    localparam int DEFAULT_DEPTH   = 512;
    localparam int DEFAULT_LATENCY = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_line_array.sv
// Single-port DEPTH x LINE_W line storage: synchronous write, registered read.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
        r_rdata <= r_mem[addr_i];
    end

    assign rdata_o = r_rdata;
endmodule

// File: rtl/dmem_line_ctrl.sv
// Line-granular data memory: latches one request, counts a fixed latency,
// then pulses ack for one cycle (read data registered on entry to ACK).
module dmem_line_ctrl
    import dmem_pkg::*;
#(
    parameter int LINE_W  = DEFAULT_LINE_W,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic              r_write;
    logic [IDX_W-1:0]  r_index;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_data_out;

    logic [IDX_W-1:0]  w_req_index;
    logic [IDX_W-1:0]  w_arr_index;
    logic              w_accept;
    logic              w_wait_done;
    logic              w_arr_we;
    logic [LINE_W-1:0] w_rd_data;
    logic              w_unused_addr;

    // Upper index bits and the byte offset are dropped on purpose: addresses alias.
    assign w_req_index   = addr_i[OFFSET_W +: IDX_W];
    assign w_unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

    assign w_accept    = (r_state == IDLE) && enable_i;
    assign w_wait_done = (r_state == WAIT) && (r_count == CNT_W'(LATENCY - 2));
    // In IDLE the array is addressed from the live request so the line is
    // already in the read register after the acceptance edge, even at LATENCY=2.
    assign w_arr_index = (r_state == IDLE) ? w_req_index : r_index;
    assign w_arr_we    = (r_state == ACK) && r_write;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable_i) w_state_next = WAIT;
            WAIT:    if (w_wait_done) w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            if (w_accept) begin
                r_count <= '0;
            end else if (r_state == WAIT) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_wait_done && !r_write) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_write <= write_i;
            r_index <= w_req_index;
            r_wdata <= data_i;
        end
    end

    dmem_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_arr_we),
        .addr_i  (w_arr_index),
        .wdata_i (r_wdata),
        .rdata_o (w_rd_data)
    );

    assign ack_o  = (r_state == ACK);
    assign busy_o = (r_state != IDLE);
    assign data_o = r_data_out;
endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Directed bench for dmem_line_ctrl: vector table plus corner-case sequences.
module tb_dmem_line_ctrl;
    localparam int LAT     = dmem_pkg::DEFAULT_LATENCY;
    localparam int ACK_OFS = LAT - 1;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         ack_o;
    logic [255:0] rdata;
    logic         busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dmem_line_ctrl dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (wdata),
        .ack_o    (ack_o),
        .data_o   (rdata),
        .busy_o   (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One request; enable held until ack is seen. Returns ack offset (cycles
    // after acceptance edge), sampled read data, and ack level one cycle later.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                          input bit scramble, output int lat,
                          output logic [255:0] rd, output logic ack_after);
        lat = -1;
        rd  = '0;
        @(negedge clk);
        enable = 1'b1;
        wr     = w;
        addr   = a;
        wdata  = d;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack_o) begin
                lat = n;
                rd  = rdata;
                break;
            end
            if (scramble) begin
                addr  = $urandom;
                wdata = {8{$urandom}};
                wr    = 1'($urandom_range(0, 1));
            end
        end
        enable = 1'b0;
        @(negedge clk);
        ack_after = ack_o;
    endtask

    initial begin
        int           lat;
        logic [255:0] rd;
        logic         ack_after;
        logic [255:0] last_rd;
        int           ack_seen;
        int           busy_bad;
        int           ack_bad;

        rst    = 1'b1;
        enable = 1'b0;
        wr     = 1'b0;
        addr   = '0;
        wdata  = '0;

        vecs[0] = '{1'b0, 32'h0000_0060, '0,           {32{8'hA5}}};
        vecs[1] = '{1'b1, 32'h0000_0080, 256'h1234,    '0};
        vecs[2] = '{1'b0, 32'h0000_0080, '0,           256'h1234};
        vecs[3] = '{1'b0, 32'h0000_4060, '0,           {32{8'hA5}}};
        vecs[4] = '{1'b0, 32'h0000_007F, '0,           {32{8'hA5}}};
        vecs[5] = '{1'b1, 32'h0000_4080, 256'h5555,    '0};
        vecs[6] = '{1'b0, 32'h0000_0080, '0,           256'h5555};
        vecs[7] = '{1'b0, 32'h0000_0040, '0,           256'hCAFE};

        #12;
        check("reset_ack",  {255'd0, ack_o},  '0);
        check("reset_busy", {255'd0, busy_o}, '0);
        check("reset_data", rdata, '0);

        dut.u_array.r_mem[1] = 256'h1111;
        dut.u_array.r_mem[2] = 256'hCAFE;
        dut.u_array.r_mem[3] = {32{8'hA5}};
        dut.u_array.r_mem[4] = '0;
        @(negedge clk);
        rst = 1'b0;

        last_rd = '0;
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, lat, rd, ack_after);
            check($sformatf("v%0d_latency", i), 256'(lat), 256'(ACK_OFS));
            check($sformatf("v%0d_single_pulse", i), {255'd0, ack_after}, '0);
            if (vecs[i].wr) begin
                check($sformatf("v%0d_data_held", i), rdata, last_rd);
            end else begin
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                last_rd = vecs[i].exp_rdata;
            end
        end

        // Inputs scrambled throughout WAIT must not disturb the latched write.
        do_req(1'b1, 32'h0000_0080, 256'h77, 1'b1, lat, rd, ack_after);
        check("scr_latency", 256'(lat), 256'(ACK_OFS));
        check("scr_mem4", dut.u_array.r_mem[4], 256'h77);
        do_req(1'b0, 32'h0000_0080, '0, 1'b0, lat, rd, ack_after);
        check("scr_readback", rd, 256'h77);

        // Asynchronous reset in WAIT cycle 5 of a write to index 1.
        @(negedge clk);
        enable = 1'b1;
        wr     = 1'b1;
        addr   = 32'h0000_0020;
        wdata  = 256'h9999;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        check("rst_busy_before", {255'd0, busy_o}, 256'd1);
        rst = 1'b1;
        #1;
        check("rst_ack_now",  {255'd0, ack_o},  '0);
        check("rst_busy_now", {255'd0, busy_o}, '0);
        check("rst_data_now", rdata, '0);
        @(negedge clk);
        enable = 1'b0;
        wr     = 1'b0;
        rst    = 1'b0;
        ack_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ack_o || busy_o) ack_seen++;
        end
        check("rst_no_late_ack", 256'(ack_seen), '0);
        check("rst_mem1_kept", dut.u_array.r_mem[1], 256'h1111);
        do_req(1'b0, 32'h0000_0020, '0, 1'b0, lat, rd, ack_after);
        check("rst_readback", rd, 256'h1111);

        // Enable held across three acks: period is LAT busy cycles + 1 idle.
        @(negedge clk);
        enable = 1'b1;
        wr     = 1'b0;
        addr   = 32'h0000_0060;
        @(posedge clk);
        ack_seen = 0;
        busy_bad = 0;
        ack_bad  = 0;
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            @(negedge clk);
            if (ack_o) ack_seen++;
            if (busy_o !== ((k % (LAT + 1)) != LAT)) busy_bad++;
            if (ack_o  !== ((k % (LAT + 1)) == LAT - 1)) ack_bad++;
            if (k == 3 * (LAT + 1) - 1) enable = 1'b0;
        end
        check("b2b_ack_count", 256'(ack_seen), 256'd3);
        check("b2b_busy_pattern", 256'(busy_bad), '0);
        check("b2b_ack_pattern", 256'(ack_bad), '0);
        check("b2b_rdata", rdata, {32{8'hA5}});
        ack_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ack_o || busy_o) ack_seen++;
        end
        check("b2b_quiet_after", 256'(ack_seen), '0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
